// File: rtl/sd_pkg.sv
// sd_pkg: constants and helpers shared by the delta-sigma
// decimator and the matching DAC.
package sd_pkg;

    // Decimated results dropped after reset while the comb delays fill.
    localparam int unsigned WARMUP_FRAMES = 2;

    // Warm-up counter type, saturating at WARMUP_FRAMES.
    typedef logic [1:0] warm_t;

    // Integrator/comb width for a sinc^2 filter with R = 2^dec_log2.
    function automatic int unsigned cic_width(input int unsigned dec_log2);
        return 2 * dec_log2 + 1;
    endfunction

    // Largest representable output before scaling: R^2 - 1.
    function automatic logic [63:0] sat_max(input int unsigned dec_log2);
        return (64'd1 << (2 * dec_log2)) - 64'd1;
    endfunction

endpackage

// File: rtl/sd_cic_stage.sv
// sd_cic_stage: one integrator plus one comb delay of a CIC filter.
// All arithmetic wraps modulo 2^W by design.
module sd_cic_stage #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         int_en_i,
    input  logic [W-1:0] int_in_i,
    output logic [W-1:0] int_q_o,
    input  logic         comb_en_i,
    input  logic [W-1:0] comb_in_i,
    output logic [W-1:0] comb_o
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W-1:0] dly_q;

    assign acc_d   = acc_q + int_in_i;
    assign int_q_o = acc_q;
    assign comb_o  = comb_in_i - dly_q;

    // Integrator accumulates only on qualified input samples.
    always_ff @(posedge clk) begin
        if (reset)
            acc_q <= '0;
        else if (int_en_i)
            acc_q <= acc_d;
    end

    // Comb delay remembers the previous decimated input.
    always_ff @(posedge clk) begin
        if (reset)
            dly_q <= '0;
        else if (comb_en_i)
            dly_q <= comb_in_i;
    end

endmodule

// File: rtl/sd_decimator.sv
// sd_decimator: sinc^2 CIC decimator turning a 1-bit delta-sigma
// stream into (RES+1)-bit unsigned samples with valid/ready output.
module sd_decimator #(
    parameter int unsigned RES      = 7,
    parameter int unsigned DEC_LOG2 = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bit_in,
    input  logic         bit_en,
    output logic [RES:0] sample_out,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic         overrun
);

    import sd_pkg::*;

    localparam int unsigned W   = cic_width(DEC_LOG2);
    localparam logic [W-1:0] SAT = W'(sat_max(DEC_LOG2));
    localparam int unsigned LSB = 2 * DEC_LOG2 - RES - 1;

    logic [DEC_LOG2-1:0] cnt_q;
    logic                tick1_q;
    logic                tick2_q;
    logic                last_bit;
    warm_t               warm_q;
    logic                warm_done;
    logic                write;

    logic [W-1:0] x_ext;
    logic [W-1:0] i1_q;
    logic [W-1:0] i1_new;
    logic [W-1:0] i2_q;
    logic [W-1:0] comb1;
    logic [W-1:0] c1_q;
    logic [W-1:0] y;
    logic [W-1:0] y_sat;
    logic [RES:0] y_scaled;

    logic [RES:0] sample_q;
    logic [RES:0] sample_d;
    logic         valid_q;
    logic         valid_d;
    logic         ovr_q;
    logic         ovr_d;

    assign x_ext     = {{(W-1){1'b0}}, bit_in};
    assign i1_new    = i1_q + x_ext;
    assign last_bit  = bit_en && (cnt_q == '1);
    assign warm_done = (warm_q == 2'(WARMUP_FRAMES));
    assign write     = tick2_q && warm_done;

    // First stage integrates the raw bit; its comb runs on tick 1.
    sd_cic_stage #(.W(W)) u_stage1 (
        .clk       (clk),
        .reset     (reset),
        .int_en_i  (bit_en),
        .int_in_i  (x_ext),
        .int_q_o   (i1_q),
        .comb_en_i (tick1_q),
        .comb_in_i (i2_q),
        .comb_o    (comb1)
    );

    // Second stage integrates the updated i1; its comb yields y on tick 2.
    sd_cic_stage #(.W(W)) u_stage2 (
        .clk       (clk),
        .reset     (reset),
        .int_en_i  (bit_en),
        .int_in_i  (i1_new),
        .int_q_o   (i2_q),
        .comb_en_i (tick2_q),
        .comb_in_i (c1_q),
        .comb_o    (y)
    );

    // Decimation counter and the two-deep frame-end tick pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            tick1_q <= 1'b0;
            tick2_q <= 1'b0;
        end else begin
            if (bit_en)
                cnt_q <= cnt_q + 1'b1;
            tick1_q <= last_bit;
            tick2_q <= tick1_q;
        end
    end

    // First comb output register, loaded one cycle after frame end.
    always_ff @(posedge clk) begin
        if (reset)
            c1_q <= '0;
        else if (tick1_q)
            c1_q <= comb1;
    end

    // Warm-up counter saturates once the comb delays hold real data.
    always_ff @(posedge clk) begin
        if (reset)
            warm_q <= '0;
        else if (tick2_q && !warm_done)
            warm_q <= warm_q + 2'd1;
    end

    // Full-scale input gives y = R^2, which must clip to R^2-1.
    always_comb begin
        y_sat    = (y > SAT) ? SAT : y;
        y_scaled = (RES+1)'(y_sat >> LSB);
    end

    // Output register, valid flag and sticky overrun next state.
    always_comb begin
        sample_d = sample_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        if (write) begin
            sample_d = y_scaled;
            valid_d  = 1'b1;
            ovr_d    = ovr_q | (valid_q & ~sample_ready);
        end else if (sample_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output-side state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sample_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            sample_q <= sample_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;

endmodule
